queue_cmd_gen: RTL and testbench

Upstream command generator for the queue block. Conditions two raw push-buttons (enqueue, dequeue) and the data switches into clean single-cycle `push`/`pop` strobes with captured `push_data`. Conditioning covers synchronisation, debounce, edge detection and full/empty gating. It replaces ad-hoc bounce handling in the queue: the queue consumes one strobe per physical press and nothing else.

---
 rtl/queue_cmd_gen.sv | 160 ++++++++++++++++
 tb/tb_queue_cmd_gen.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_cmd_gen.sv
// rtl/queue_cmd_gen.sv - button conditioning into single-cycle push/pop strobes
// Per-channel synchroniser + debounce FSM, then full/empty gated command issue.

module queue_cmd_gen_db #(
  parameter int DB_W   = 20,
  parameter int DB_MAX = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

  // Compare one early so the transition lands exactly as the count reaches DB_MAX-1
  localparam logic [DB_W-1:0] LP_LAST = DB_W'(DB_MAX - 2);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DB_W-1:0] r_cnt;
  logic [DB_W-1:0] w_cnt_nxt;
  logic [1:0]      r_sync;
  logic            r_press;
  logic            w_press;
  logic            w_sync;

  assign w_sync = r_sync[1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sync  <= '0;
      r_press <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sync  <= {r_sync[0], i_btn};
      r_press <= w_press;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_sync) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_sync) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + DB_W'(1);
          if (r_cnt == LP_LAST) w_state_nxt = HELD;
        end
      end
      HELD: begin
        if (!w_sync) begin
          w_state_nxt = REL_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      REL_WAIT: begin
        if (w_sync) begin
          w_state_nxt = HELD;
        end else begin
          w_cnt_nxt = r_cnt + DB_W'(1);
          if (r_cnt == LP_LAST) w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    w_press = (r_state == PRESS_WAIT) && w_sync && (r_cnt == LP_LAST);
  end

  assign o_press = r_press;
endmodule

module queue_cmd_gen #(
  parameter int QW     = 4,
  parameter int DB_W   = 20,
  parameter int DB_MAX = 1_000_000
) (
  input  logic          i_clk100,
  input  logic          i_rst_n,
  input  logic          i_btn_in,
  input  logic          i_btn_out,
  input  logic [QW-1:0] i_sw,
  input  logic          i_full,
  input  logic          i_empty,
  output logic          o_push,
  output logic [QW-1:0] o_push_data,
  output logic          o_pop,
  output logic          o_push_rej,
  output logic          o_pop_rej
);
  logic          w_press_in;
  logic          w_press_out;
  logic          w_pop_req;
  logic          w_pend_nxt;
  logic          r_pend;
  logic          r_push;
  logic          r_pop;
  logic          r_push_rej;
  logic          r_pop_rej;
  logic [QW-1:0] r_push_data;

  queue_cmd_gen_db #(.DB_W(DB_W), .DB_MAX(DB_MAX)) u_db_in (
    .i_clk   (i_clk100),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_in),
    .o_press (w_press_in)
  );

  queue_cmd_gen_db #(.DB_W(DB_W), .DB_MAX(DB_MAX)) u_db_out (
    .i_clk   (i_clk100),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_out),
    .o_press (w_press_out)
  );

  // Enqueue wins a same-cycle collision; the dequeue waits one cycle in r_pend
  always_comb begin
    w_pop_req  = w_press_out || r_pend;
    w_pend_nxt = w_pop_req && w_press_in;
  end

  always_ff @(posedge i_clk100) begin
    if (!i_rst_n) begin
      r_pend      <= 1'b0;
      r_push      <= 1'b0;
      r_pop       <= 1'b0;
      r_push_rej  <= 1'b0;
      r_pop_rej   <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_push     <= w_press_in && !i_full;
      r_push_rej <= w_press_in && i_full;
      r_pop      <= w_pop_req && !w_press_in && !i_empty;
      r_pop_rej  <= w_pop_req && !w_press_in && i_empty;
      if (w_press_in && !i_full) r_push_data <= i_sw;
    end
  end

  assign o_push      = r_push;
  assign o_pop       = r_pop;
  assign o_push_rej  = r_push_rej;
  assign o_pop_rej   = r_pop_rej;
  assign o_push_data = r_push_data;
endmodule

// File: tb/tb_queue_cmd_gen.sv
// tb/tb_queue_cmd_gen.sv - self-checking bench for queue_cmd_gen
// Reference model: integrating debouncer (run of disagreeing samples flips the level).

module tb_queue_cmd_gen;
  localparam int QW     = 4;
  localparam int DB_W   = 4;
  localparam int DB_MAX = 8;
  localparam int LAT    = DB_MAX + 2;
  localparam int SETTLE = 2 * DB_MAX + 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn_in = 1'b0;
  logic          btn_out = 1'b0;
  logic [QW-1:0] sw = '0;
  logic          full = 1'b0;
  logic          empty = 1'b0;
  logic          push;
  logic          pop;
  logic          push_rej;
  logic          pop_rej;
  logic [QW-1:0] push_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int n_push, n_pop, n_prej, n_orej, n_multi;
  int t_push, t_pop, t_prej, t_orej;

  bit [1:0]      m_sync [2];
  bit            m_lvl  [2];
  int            m_run  [2];
  bit            m_evt  [2];
  bit            m_pend;
  bit            e_push, e_pop, e_push_rej, e_pop_rej;
  logic [QW-1:0] e_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  queue_cmd_gen #(.QW(QW), .DB_W(DB_W), .DB_MAX(DB_MAX)) dut (
    .i_clk100    (clk),
    .i_rst_n     (rst_n),
    .i_btn_in    (btn_in),
    .i_btn_out   (btn_out),
    .i_sw        (sw),
    .i_full      (full),
    .i_empty     (empty),
    .o_push      (push),
    .o_push_data (push_data),
    .o_pop       (pop),
    .o_push_rej  (push_rej),
    .o_pop_rej   (pop_rej)
  );

  task automatic model_step();
    bit req;
    bit s;
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        m_sync[c] = 2'b00; m_lvl[c] = 1'b0; m_run[c] = 0; m_evt[c] = 1'b0;
      end
      m_pend = 1'b0;
      e_push = 1'b0; e_pop = 1'b0; e_push_rej = 1'b0; e_pop_rej = 1'b0; e_data = '0;
    end else begin
      req        = m_pend || m_evt[1];
      e_push     = m_evt[0] && !full;
      e_push_rej = m_evt[0] && full;
      if (e_push) e_data = sw;
      e_pop      = req && !m_evt[0] && !empty;
      e_pop_rej  = req && !m_evt[0] && empty;
      m_pend     = req && m_evt[0];
      for (int c = 0; c < 2; c++) begin
        s = m_sync[c][1];
        m_evt[c] = 1'b0;
        if (s == m_lvl[c]) begin
          m_run[c] = 0;
        end else begin
          m_run[c]++;
          if (m_run[c] == DB_MAX) begin
            m_lvl[c] = s;
            m_run[c] = 0;
            m_evt[c] = s;
          end
        end
        m_sync[c] = {m_sync[c][0], (c == 0) ? btn_in : btn_out};
      end
    end
  endtask

  task automatic clear_obs();
    n_push = 0; n_pop = 0; n_prej = 0; n_orej = 0; n_multi = 0;
    t_push = -1; t_pop = -1; t_prej = -1; t_orej = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (push)     begin n_push++; t_push = cyc; end
    if (pop)      begin n_pop++;  t_pop  = cyc; end
    if (push_rej) begin n_prej++; t_prej = cyc; end
    if (pop_rej)  begin n_orej++; t_orej = cyc; end
    if (int'(push) + int'(pop) + int'(push_rej) + int'(pop_rej) > 1) n_multi++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({push, pop, push_rej, pop_rej, push_data} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 00", {push, pop, push_rej, pop_rej, push_data});
    end
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_clean_press();
    int t;
    clear_obs();
    sw = 4'hA; full = 1'b0; btn_in = 1'b1;
    t = cyc + 1;
    repeat (31) begin
      tick();
      vectors++;
      if ({push, pop, push_rej, pop_rej, push_data} !== {e_push, e_pop, e_push_rej, e_pop_rej, e_data}) begin
        miscompares++;
        $display("FAIL clean_model cyc=%0d: got %h expected %h", cyc,
                 {push, pop, push_rej, pop_rej, push_data}, {e_push, e_pop, e_push_rej, e_pop_rej, e_data});
      end
    end
    vectors++;
    if (n_push !== 1) begin miscompares++; $display("FAIL clean_count: got %0d expected 1", n_push); end
    vectors++;
    if (t_push !== t + LAT) begin miscompares++; $display("FAIL clean_latency: got %0d expected %0d", t_push, t + LAT); end
    vectors++;
    if (push_data !== 4'hA) begin miscompares++; $display("FAIL clean_data_held: got %h expected a", push_data); end
    btn_in = 1'b0;
    repeat (SETTLE) tick();
  endtask

  task automatic test_bounce();
    int t;
    clear_obs();
    empty = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btn_out = 1'b1; repeat (3) tick();
      btn_out = 1'b0; repeat (3) tick();
    end
    btn_out = 1'b1;
    t = cyc + 1;
    repeat (20) tick();
    vectors++;
    if (n_pop !== 1) begin miscompares++; $display("FAIL bounce_count: got %0d expected 1", n_pop); end
    vectors++;
    if (t_pop !== t + LAT) begin miscompares++; $display("FAIL bounce_latency: got %0d expected %0d", t_pop, t + LAT); end
    vectors++;
    if (n_orej + n_push + n_prej !== 0) begin miscompares++; $display("FAIL bounce_other: got %0d expected 0", n_orej + n_push + n_prej); end
    btn_out = 1'b0;
    repeat (SETTLE) tick();
  endtask

  task automatic test_gating();
    int t;
    clear_obs();
    sw = 4'h5; full = 1'b1; btn_in = 1'b1;
    t = cyc + 1;
    repeat (14) tick();
    vectors++;
    if (n_prej !== 1 || t_prej !== t + LAT) begin
      miscompares++; $display("FAIL push_rej: got count %0d at %0d expected 1 at %0d", n_prej, t_prej, t + LAT);
    end
    vectors++;
    if (n_push !== 0) begin miscompares++; $display("FAIL push_when_full: got %0d expected 0", n_push); end
    vectors++;
    if (push_data !== 4'hA) begin miscompares++; $display("FAIL data_unchanged: got %h expected a", push_data); end
    btn_in = 1'b0; full = 1'b0;
    repeat (SETTLE) tick();
    clear_obs();
    empty = 1'b1; btn_out = 1'b1;
    t = cyc + 1;
    repeat (14) tick();
    vectors++;
    if (n_orej !== 1 || t_orej !== t + LAT) begin
      miscompares++; $display("FAIL pop_rej: got count %0d at %0d expected 1 at %0d", n_orej, t_orej, t + LAT);
    end
    vectors++;
    if (n_pop + n_push + n_prej !== 0) begin miscompares++; $display("FAIL pop_when_empty: got %0d expected 0", n_pop + n_push + n_prej); end
    btn_out = 1'b0;
    repeat (SETTLE) tick();
  endtask

  task automatic test_simultaneous();
    int t;
    clear_obs();
    full = 1'b0; empty = 1'b1; sw = 4'h3;
    btn_in = 1'b1; btn_out = 1'b1;
    t = cyc + 1;
    repeat (16) begin
      tick();
      if (push) empty = 1'b0;
    end
    vectors++;
    if (n_push !== 1 || t_push !== t + LAT) begin
      miscompares++; $display("FAIL simul_push: got count %0d at %0d expected 1 at %0d", n_push, t_push, t + LAT);
    end
    vectors++;
    if (n_pop !== 1 || t_pop !== t + LAT + 1) begin
      miscompares++; $display("FAIL simul_pop: got count %0d at %0d expected 1 at %0d", n_pop, t_pop, t + LAT + 1);
    end
    vectors++;
    if (n_orej !== 0 || n_multi !== 0) begin
      miscompares++; $display("FAIL simul_excl: got rej %0d multi %0d expected 0 0", n_orej, n_multi);
    end
    btn_in = 1'b0; btn_out = 1'b0;
    repeat (SETTLE) tick();
  endtask

  task automatic test_hold_release();
    int t;
    clear_obs();
    full = 1'b0; sw = 4'h6;
    btn_in = 1'b1;
    repeat (100) tick();
    btn_in = 1'b0; repeat (2) tick();
    btn_in = 1'b1; tick();
    btn_in = 1'b0; repeat (2) tick();
    btn_in = 1'b1; tick();
    btn_in = 1'b0; repeat (20) tick();
    btn_in = 1'b1;
    t = cyc + 1;
    repeat (14) tick();
    vectors++;
    if (n_push !== 2) begin miscompares++; $display("FAIL hold_count: got %0d expected 2", n_push); end
    vectors++;
    if (t_push !== t + LAT) begin miscompares++; $display("FAIL repress_latency: got %0d expected %0d", t_push, t + LAT); end
    btn_in = 1'b0;
    repeat (SETTLE) tick();
  endtask

  task automatic test_reset_midop();
    int t;
    clear_obs();
    full = 1'b0; sw = 4'h9;
    btn_in = 1'b1;
    t = cyc + 1;
    while (cyc < t + 7) tick();
    rst_n = 1'b0;
    tick();
    vectors++;
    if ({push, pop, push_rej, pop_rej, push_data} !== 8'h00) begin
      miscompares++;
      $display("FAIL midop_reset_outputs: got %h expected 00", {push, pop, push_rej, pop_rej, push_data});
    end
    repeat (3) tick();
    vectors++;
    if (n_push + n_prej !== 0) begin miscompares++; $display("FAIL midop_no_strobe: got %0d expected 0", n_push + n_prej); end
    rst_n = 1'b1;
    t = cyc + 1;
    repeat (16) tick();
    vectors++;
    if (n_push !== 1 || t_push !== t + LAT) begin
      miscompares++; $display("FAIL post_reset_press: got count %0d at %0d expected 1 at %0d", n_push, t_push, t + LAT);
    end
    vectors++;
    if (push_data !== 4'h9) begin miscompares++; $display("FAIL post_reset_data: got %h expected 9", push_data); end
    btn_in = 1'b0;
    repeat (SETTLE) tick();
  endtask

  task automatic test_random();
    clear_obs();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) btn_in = ~btn_in;
      if ($urandom_range(0, 11) == 0) btn_out = ~btn_out;
      full  = ($urandom_range(0, 3) == 0);
      empty = ($urandom_range(0, 3) == 0);
      sw    = QW'($urandom);
      tick();
      vectors++;
      if ({push, pop, push_rej, pop_rej, push_data} !== {e_push, e_pop, e_push_rej, e_pop_rej, e_data}) begin
        miscompares++;
        $display("FAIL random_model cyc=%0d: got %h expected %h", cyc,
                 {push, pop, push_rej, pop_rej, push_data}, {e_push, e_pop, e_push_rej, e_pop_rej, e_data});
      end
    end
    vectors++;
    if (n_multi !== 0) begin miscompares++; $display("FAIL random_onehot: got %0d expected 0", n_multi); end
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_clean_press();
    test_bounce();
    test_gating();
    test_simultaneous();
    test_hold_release();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
